// File: rtl/sort4_pkg.sv
// Shared types and constants for the 4-element sorter: FSM states, batch
// defaults and the fixed compare schedule.
package sort4_pkg;

  localparam int W_DEF   = 4;
  localparam int N_DEF   = 4;
  localparam int N_STEPS = 6;

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  // Compare-pair table: step index -> lower element index j of pair (j, j+1).
  function automatic logic [1:0] pair_j(input logic [2:0] step);
    case (step)
      3'd0:    pair_j = 2'd0;
      3'd1:    pair_j = 2'd1;
      3'd2:    pair_j = 2'd2;
      3'd3:    pair_j = 2'd0;
      3'd4:    pair_j = 2'd1;
      default: pair_j = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mag_comp4.sv
// Unsigned magnitude comparator shared by every compare step of the sorter.
module mag_comp4
  import sort4_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/sort4_ctrl.sv
// Batch sorter: loads 4 unsigned elements, bubble-sorts them in 6 fixed
// compare steps through one comparator, then streams them out ascending.
module sort4_ctrl
  import sort4_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic [2:0]   swap_count,
  output logic         done
);

  localparam logic [1:0] LAST_IDX  = 2'(N - 1);
  localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

  state_t       state, state_nx;
  logic [1:0]   load_idx, out_idx;
  logic [2:0]   step;
  logic [W-1:0] elem [0:3];
  logic [1:0]   j;
  logic [W-1:0] cmp_a, cmp_b;
  logic         gt, lt, eq;
  logic         unused_cmp;

  assign j          = pair_j(step);
  assign cmp_a      = elem[j];
  assign cmp_b      = elem[j + 2'd1];
  assign unused_cmp = lt ^ eq;

  mag_comp4 #(.W(W)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt),
    .lt (lt),
    .eq (eq)
  );

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign busy      = (state == SORT) || (state == OUT);
  assign out_data  = elem[out_idx];

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_valid && load_idx == LAST_IDX) state_nx = SORT;
      SORT:    if (step == LAST_STEP)                state_nx = OUT;
      OUT:     if (out_ready && out_idx == LAST_IDX) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      load_idx   <= '0;
      out_idx    <= '0;
      step       <= '0;
      swap_count <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        LOAD: if (in_valid) begin
          if (load_idx == LAST_IDX) begin
            load_idx   <= '0;
            step       <= '0;
            swap_count <= '0;
          end else begin
            load_idx <= load_idx + 2'd1;
          end
        end
        SORT: begin
          if (gt) swap_count <= swap_count + 3'd1;
          if (step == LAST_STEP) begin
            step    <= '0;
            out_idx <= '0;
          end else begin
            step <= step + 3'd1;
          end
        end
        OUT: if (out_ready) begin
          if (out_idx == LAST_IDX) begin
            out_idx  <= '0;
            load_idx <= '0;
            done     <= 1'b1;
          end else begin
            out_idx <= out_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Element register file carries no reset; its contents only matter once loaded.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      elem[load_idx] <= in_data;
    end else if (state == SORT && gt) begin
      elem[j]        <= cmp_b;
      elem[j + 2'd1] <= cmp_a;
    end
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Scoreboard bench for sort4_ctrl: directed batches push expected sorted
// outputs; a negedge monitor pops and compares on each output handshake.
module tb_sort4_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic [2:0] swap_count;
  logic       done;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         done_cnt = 0;
  logic [3:0] sb [$];

  sort4_ctrl #(.W(4), .N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .swap_count (swap_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got %0d, expected no output", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic load4(input logic [15:0] din, input int gap);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = 0;
      while (in_ready !== 1'b1 && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_data  = din[15-4*i -: 4];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input string nm, input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) chk({nm, "_done_timeout"}, 32'(done_cnt - d0), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic finish_checks(input string nm, input int d0, input int swaps);
    chk({nm, "_swap_count"}, 32'(swap_count), 32'(swaps));
    chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_batch(input string nm, input logic [15:0] din, input logic [15:0] exp,
                           input int swaps, input int gap, input bit lat);
    int d0;
    int first;
    for (int i = 0; i < 4; i++) sb.push_back(exp[15-4*i -: 4]);
    d0 = done_cnt;
    load4(din, gap);
    if (lat) begin
      first = -1;
      for (int k = 1; k <= 10; k++) begin
        if (out_valid === 1'b1 && first < 0) first = k;
        @(posedge clk); #1;
      end
      chk({nm, "_latency"}, 32'(first), 32'd7);
    end
    wait_done(nm, d0);
    finish_checks(nm, d0, swaps);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_swap_count", 32'(swap_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_batch("s1", 16'h9371, 16'h1379, 5, 0, 1'b0);
    run_batch("s2", 16'h1234, 16'h1234, 0, 0, 1'b1);
    run_batch("s3", 16'hFA50, 16'h05AF, 6, 0, 1'b0);
    run_batch("s4", 16'h5525, 16'h2555, 2, 2, 1'b0);

    // Output back-pressure at out_idx=1.
    for (int i = 0; i < 4; i++) sb.push_back(4'(i == 0 ? 1 : i == 1 ? 3 : i == 2 ? 7 : 9));
    d0 = done_cnt;
    load4(16'h9371, 0);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) chk("s5_out_valid_timeout", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("s5_hold_data", 32'(out_data), 32'd3);
      chk("s5_hold_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done("s5", d0);
    finish_checks("s5", d0, 5);

    // Reset in SORT step 3 discards the batch.
    load4(16'h8642, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("s6_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("s6_in_ready", 32'(in_ready), 32'd1);
    chk("s6_out_valid", 32'(out_valid), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_swap_count", 32'(swap_count), 32'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("s6_idle_out_valid", 32'(out_valid), 32'd0);
    run_batch("s6b", 16'h4321, 16'h1234, 6, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
